cnt_24: RTL and testbench



---
 rtl/cnt_24.sv | 54 +++++
 tb/tb_cnt_24.sv | 99 +++++++++
 2 files changed

// File: rtl/cnt_24.sv
// cnt_24: modulo-24 hour counter, BCD pair plus binary copy; optional wrap pulse under CNT24_CARRY_OUT_EN
module cnt_24 (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_en,
  input  logic       cnt_inc,
  output logic [1:0] cnt_hi,
  output logic [3:0] cnt_lo,
  output logic [4:0] cnt_bin
`ifdef CNT24_CARRY_OUT_EN
  ,
  output logic       cnt_carry
`endif
);
  logic [1:0] r_hi;
  logic [3:0] r_lo;
  logic [4:0] r_bin;
  logic       r_carry;
  logic       w_step;
  logic       w_top;
  logic       w_wrap;
  logic       w_lo_wrap;
  // forced illegal BCD states fold into the hour wrap so the next step lands on 0
  always_comb begin
    w_step    = cnt_en | cnt_inc;
    w_top     = r_hi == 2'd2 && r_lo == 4'd3;
    w_wrap    = (r_hi == 2'd2 && r_lo >= 4'd3) || r_hi == 2'd3 || r_lo > 4'd9;
    w_lo_wrap = r_lo == 4'd9;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_bin   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_step & w_top;
      if (w_step) begin
        r_hi  <= w_wrap ? 2'd0 : w_lo_wrap ? r_hi + 2'd1 : r_hi;
        r_lo  <= w_wrap || w_lo_wrap ? 4'd0 : r_lo + 4'd1;
        r_bin <= w_wrap ? 5'd0 : r_bin + 5'd1;
      end
    end
  end
  assign cnt_hi  = r_hi;
  assign cnt_lo  = r_lo;
  assign cnt_bin = r_bin;
`ifdef CNT24_CARRY_OUT_EN
  assign cnt_carry = r_carry;
`else
  logic w_unused;
  assign w_unused = r_carry;
`endif
endmodule

// File: tb/tb_cnt_24.sv
// tb_cnt_24: directed bench for cnt_24; tracks the expected hour locally and checks all outputs
module tb_cnt_24;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt_en = 1'b0;
  logic       cnt_inc = 1'b0;
  logic [1:0] cnt_hi;
  logic [3:0] cnt_lo;
  logic [4:0] cnt_bin;
`ifdef CNT24_CARRY_OUT_EN
  logic       cnt_carry;
`endif
  int checks = 0;
  int failures = 0;
  int e_val = 0;
  int e_carry = 0;
  cnt_24 dut (
    .clk(clk),
    .rst(rst),
    .cnt_en(cnt_en),
    .cnt_inc(cnt_inc),
    .cnt_hi(cnt_hi),
    .cnt_lo(cnt_lo),
    .cnt_bin(cnt_bin)
`ifdef CNT24_CARRY_OUT_EN
    ,
    .cnt_carry(cnt_carry)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".hi"}, int'(cnt_hi), e_val / 10);
    chk({tag, ".lo"}, int'(cnt_lo), e_val % 10);
    chk({tag, ".bin"}, int'(cnt_bin), e_val);
`ifdef CNT24_CARRY_OUT_EN
    chk({tag, ".carry"}, int'(cnt_carry), e_carry);
`endif
  endtask
  // advance one edge; the local model steps unless reset is high
  task automatic tick(input string tag);
    logic step;
    step = cnt_en | cnt_inc;
    @(posedge clk);
    #1;
    if (rst) begin
      e_val = 0;
      e_carry = 0;
    end else begin
      e_carry = (step && e_val == 23) ? 1 : 0;
      if (step) e_val = (e_val + 1) % 24;
    end
    chk_all(tag);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) tick("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("reset_hold");
    cnt_en = 1'b1;
    for (int i = 0; i < 40; i++) tick("en_run");
    chk("en_final", int'(cnt_bin), 16);
    cnt_en = 1'b0;
    for (int i = 0; i < 10; i++) tick("en_hold");
    cnt_en = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick("mid_reset");
    rst = 1'b0;
    tick("first_after_reset");
    chk("first_is_one", int'(cnt_bin), 1);
    cnt_en = 1'b0;
    rst = 1'b1;
    tick("reset2");
    rst = 1'b0;
    cnt_inc = 1'b1;
    for (int i = 0; i < 40; i++) tick("inc_run");
    chk("inc_final", int'(cnt_bin), 16);
    cnt_inc = 1'b0;
    for (int i = 0; i < 10; i++) tick("inc_hold");
    rst = 1'b1;
    tick("reset3");
    rst = 1'b0;
    cnt_en = 1'b1;
    cnt_inc = 1'b1;
    for (int i = 0; i < 24; i++) tick("both_run");
    chk("both_wrap_bin", int'(cnt_bin), 0);
    chk("both_wrap_hi", int'(cnt_hi), 0);
    cnt_en = 1'b0;
    cnt_inc = 1'b0;
    for (int i = 0; i < 3; i++) tick("final_hold");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
